// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the two-port ram arbiter.
// Holds the FSM state enum, the port ids and the byte-merge function for read-modify-write.
package ram_arb_pkg;

    localparam int RAM_ADDR_W = 12;
    localparam int RAM_DATA_W = 32;
    localparam int RAM_BE_W   = RAM_DATA_W / 8;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RD_RESP,
        RMW_WR
    } arb_state_e;

    function automatic logic [RAM_DATA_W-1:0] be_merge(
        input logic [RAM_DATA_W-1:0] wdata,
        input logic [RAM_DATA_W-1:0] old,
        input logic [RAM_BE_W-1:0]   be
    );
        logic [RAM_DATA_W-1:0] merged;
        for (int b = 0; b < RAM_BE_W; b++) begin
            merged[8*b +: 8] = be[b] ? wdata[8*b +: 8] : old[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin pick, purely combinational.
// When both ports request, the port that did not win last time is chosen.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       idx
);

    always_comb begin
        idx = PORT_IF;
        if (req == 2'b11) begin
            idx = ~last;
        end else if (req[1]) begin
            idx = PORT_LS;
        end
        gnt = 2'b00;
        if (req != 2'b00) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port ram between instruction fetch (port 0) and load/store (port 1).
// Reads take two cycles; partial-word stores are done as a load followed by a merged store.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter  int ADDR_W = RAM_ADDR_W,
    parameter  int DATA_W = RAM_DATA_W,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_i,
    input  logic [1:0]             we_i,
    input  logic [1:0][ADDR_W-1:0] addr_i,
    input  logic [1:0][DATA_W-1:0] wdata_i,
    input  logic [1:0][BE_W-1:0]   be_i,
    output logic [1:0]             gnt_o,
    output logic [1:0]             rvalid_o,
    output logic [DATA_W-1:0]      rdata_o,
    output logic [ADDR_W-1:0]      ram_addr_o,
    output logic [DATA_W-1:0]      ram_din_o,
    output logic                   ram_st_o,
    output logic                   ram_ld_o,
    input  logic [DATA_W-1:0]      ram_dout_i
);

    arb_state_e        state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;

    logic [1:0] arb_gnt;
    logic       arb_idx;

    rr_arb2 u_rr_arb2 (
        .req  (req_i),
        .last (last_gnt_q),
        .gnt  (arb_gnt),
        .idx  (arb_idx)
    );

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        id_d       = id_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        gnt_o      = 2'b00;
        rvalid_o   = 2'b00;
        rdata_o    = '0;
        ram_addr_o = '0;
        ram_din_o  = '0;
        ram_st_o   = 1'b0;
        ram_ld_o   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_i != 2'b00) begin
                    gnt_o      = arb_gnt;
                    last_gnt_d = arb_idx;
                    id_d       = arb_idx;
                    addr_d     = addr_i[arb_idx];
                    wdata_d    = wdata_i[arb_idx];
                    be_d       = be_i[arb_idx];
                    ram_addr_o = addr_i[arb_idx];
                    if (!we_i[arb_idx]) begin
                        ram_ld_o = 1'b1;
                        state_d  = RD_RESP;
                    end else if (&be_i[arb_idx]) begin
                        ram_st_o  = 1'b1;
                        ram_din_o = wdata_i[arb_idx];
                    end else if (|be_i[arb_idx]) begin
                        // Fetch the old word so the untouched bytes survive the store
                        ram_ld_o = 1'b1;
                        state_d  = RMW_WR;
                    end
                end
            end
            RD_RESP: begin
                rvalid_o[id_q] = 1'b1;
                rdata_o        = ram_dout_i;
                state_d        = IDLE;
            end
            RMW_WR: begin
                ram_st_o   = 1'b1;
                ram_addr_o = addr_q;
                ram_din_o  = be_merge(wdata_q, ram_dout_i, be_q);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A reset in RD_RESP or RMW_WR must not leak a response or a store
        if (rst) begin
            gnt_o      = 2'b00;
            rvalid_o   = 2'b00;
            rdata_o    = '0;
            ram_addr_o = '0;
            ram_din_o  = '0;
            ram_st_o   = 1'b0;
            ram_ld_o   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_gnt_q <= PORT_LS;
            id_q       <= PORT_IF;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic checked every cycle
// against a transaction-level model of the arbiter and a reference memory.
module tb_ram_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BW = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         req_i, we_i;
    logic [1:0][AW-1:0] addr_i;
    logic [1:0][DW-1:0] wdata_i;
    logic [1:0][BW-1:0] be_i;
    logic [1:0]         gnt_o, rvalid_o;
    logic [DW-1:0]      rdata_o, ram_din_o, ram_dout;
    logic [AW-1:0]      ram_addr_o;
    logic               ram_st_o, ram_ld_o;

    ram_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .be_i       (be_i),
        .gnt_o      (gnt_o),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .ram_addr_o (ram_addr_o),
        .ram_din_o  (ram_din_o),
        .ram_st_o   (ram_st_o),
        .ram_ld_o   (ram_ld_o),
        .ram_dout_i (ram_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9e37_79b1) ^ 32'h5a5a_0f0f;
    endfunction

    // The ram the arbiter drives
    logic [DW-1:0] ram_mem [4096];
    logic          ram_init;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 4096; i++) ram_mem[i] <= init_word(i);
        end else begin
            if (ram_ld_o) ram_dout <= ram_mem[ram_addr_o];
            if (ram_st_o) ram_mem[ram_addr_o] <= ram_din_o;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level model: 0 = free, 1 = read response due, 2 = merged store due
    int            m_pend;
    int            m_port;
    int            m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [BW-1:0] m_be;
    logic [1:0]    m_gnt;
    logic [DW-1:0] ref_mem [4096];

    task automatic model_cycle();
        logic [1:0]    e_gnt, e_rv;
        logic          e_st, e_ld;
        logic [DW-1:0] e_rd, e_din;
        logic [AW-1:0] e_addr;
        int            w;
        e_gnt = 2'b00; e_rv = 2'b00; e_st = 1'b0; e_ld = 1'b0;
        e_rd = '0; e_din = '0; e_addr = '0; w = -1;
        if (rst) begin
            chk("rst_gnt", gnt_o, 0);
            chk("rst_rvalid", rvalid_o, 0);
            chk("rst_st", ram_st_o, 0);
            chk("rst_ld", ram_ld_o, 0);
            m_pend = 0;
            m_last = 1;
            m_gnt  = 2'b00;
            return;
        end
        if (m_pend == 1) begin
            e_rv = 2'(1 << m_port);
            e_rd = ref_mem[m_addr];
        end else if (m_pend == 2) begin
            e_st   = 1'b1;
            e_addr = m_addr;
            for (int b = 0; b < BW; b++)
                e_din[8*b +: 8] = m_be[b] ? m_wdata[8*b +: 8] : ref_mem[m_addr][8*b +: 8];
        end else if (req_i != 2'b00) begin
            w      = (req_i == 2'b11) ? 1 - m_last : (req_i[1] ? 1 : 0);
            e_gnt  = 2'(1 << w);
            e_addr = addr_i[w];
            if (!we_i[w]) e_ld = 1'b1;
            else if (be_i[w] == 4'hf) begin
                e_st  = 1'b1;
                e_din = wdata_i[w];
            end else if (be_i[w] != 4'h0) e_ld = 1'b1;
        end

        chk("gnt", gnt_o, e_gnt);
        chk("rvalid", rvalid_o, e_rv);
        chk("ram_st", ram_st_o, e_st);
        chk("ram_ld", ram_ld_o, e_ld);
        if (e_rv != 2'b00) chk("rdata", rdata_o, e_rd);
        if (e_st || e_ld) chk("ram_addr", ram_addr_o, e_addr);
        if (e_st) chk("ram_din", ram_din_o, e_din);

        if (m_pend == 2) ref_mem[m_addr] = e_din;
        if (m_pend != 0) m_pend = 0;
        else if (w >= 0) begin
            m_last  = w;
            m_port  = w;
            m_addr  = addr_i[w];
            m_wdata = wdata_i[w];
            m_be    = be_i[w];
            if (!we_i[w]) m_pend = 1;
            else if (be_i[w] == 4'hf) ref_mem[addr_i[w]] = wdata_i[w];
            else if (be_i[w] != 4'h0) m_pend = 2;
        end
        m_gnt = e_gnt;
    endtask

    task automatic tick();
        #1;
        model_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic setp(input int p, input logic r, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [BW-1:0] be);
        req_i[p]   = r;
        we_i[p]    = we;
        addr_i[p]  = a;
        wdata_i[p] = wd;
        be_i[p]    = be;
    endtask

    task automatic new_req(input int p);
        int sel;
        logic [BW-1:0] be;
        sel = $urandom_range(0, 8);
        be  = 4'($urandom);
        case ($urandom_range(0, 5))
            0, 1: be = 4'hf;
            2:    be = 4'h0;
            default: ;
        endcase
        setp(p, 1'b1, 1'($urandom), (sel == 8) ? 12'hfff : 12'(sel), $urandom, be);
    endtask

    logic [1:0] cont_gnt [6] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    logic [1:0] cont_rv  [6] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

    initial begin
        rst = 1'b1; ram_init = 1'b1;
        req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; be_i = '0;
        m_pend = 0; m_last = 1; m_gnt = '0; m_port = 0;
        m_addr = '0; m_wdata = '0; m_be = '0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
        @(negedge clk);

        // Reset with both ports requesting: nothing may be granted
        req_i = 2'b11;
        #1;
        chk("reset_gnt_forced", gnt_o, 2'b00);
        tick();
        ram_init = 1'b0; rst = 1'b0; req_i = 2'b00;
        #1;
        chk("reset_rvalid", rvalid_o, 2'b00);
        chk("reset_rdata", rdata_o, 32'h0);
        chk("reset_ram_addr", ram_addr_o, 32'h0);
        chk("reset_ram_din", ram_din_o, 32'h0);
        tick();

        // Full write then read at 123
        setp(0, 1'b1, 1'b1, 12'd123, 32'h1234_cdef, 4'hf);
        #1;
        chk("wr_gnt", gnt_o, 2'b01);
        chk("wr_st", ram_st_o, 1'b1);
        chk("wr_din", ram_din_o, 32'h1234_cdef);
        tick();
        setp(0, 1'b1, 1'b0, 12'd123, 32'h0, 4'h0);
        #1;
        chk("rd_gnt", gnt_o, 2'b01);
        chk("rd_ld", ram_ld_o, 1'b1);
        tick();
        req_i[0] = 1'b0;
        #1;
        chk("rd_rvalid", rvalid_o, 2'b01);
        chk("rd_rdata", rdata_o, 32'h1234_cdef);
        tick();

        // Contention from a fresh reset: grants 0,1,0 with responses between
        rst = 1'b1;
        tick();
        rst = 1'b0;
        setp(0, 1'b1, 1'b0, 12'h001, 32'h0, 4'h0);
        setp(1, 1'b1, 1'b0, 12'h002, 32'h0, 4'h0);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("cont_gnt", gnt_o, cont_gnt[k]);
            chk("cont_rvalid", rvalid_o, cont_rv[k]);
            tick();
        end
        req_i = 2'b00;
        tick();

        // Read-modify-write on 12'h010
        setp(1, 1'b1, 1'b1, 12'h010, 32'haabb_ccdd, 4'hf);
        tick();
        setp(1, 1'b1, 1'b1, 12'h010, 32'h1122_3344, 4'b0101);
        #1;
        chk("rmw_gnt", gnt_o, 2'b10);
        chk("rmw_ld", ram_ld_o, 1'b1);
        tick();
        req_i[1] = 1'b0;
        #1;
        chk("rmw_st", ram_st_o, 1'b1);
        chk("rmw_addr", ram_addr_o, 32'h010);
        chk("rmw_din", ram_din_o, 32'haa22_cc44);
        tick();
        setp(0, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
        tick();
        req_i[0] = 1'b0;
        #1;
        chk("rmw_readback", rdata_o, 32'haa22_cc44);
        tick();

        // Top address and zero-byte write
        setp(0, 1'b1, 1'b1, 12'hfff, 32'hffff_ffff, 4'hf);
        tick();
        setp(0, 1'b1, 1'b0, 12'hfff, 32'h0, 4'h0);
        tick();
        req_i[0] = 1'b0;
        #1;
        chk("fff_readback", rdata_o, 32'hffff_ffff);
        tick();
        setp(1, 1'b1, 1'b1, 12'hfff, 32'h0, 4'h0);
        #1;
        chk("zb_gnt", gnt_o, 2'b10);
        chk("zb_st", ram_st_o, 1'b0);
        chk("zb_ld", ram_ld_o, 1'b0);
        tick();
        req_i[1] = 1'b0;
        #1;
        chk("zb_st_next", ram_st_o, 1'b0);
        tick();
        setp(0, 1'b1, 1'b0, 12'hfff, 32'h0, 4'h0);
        tick();
        req_i[0] = 1'b0;
        #1;
        chk("zb_readback", rdata_o, 32'hffff_ffff);
        tick();

        // Reset landing on the RMW_WR cycle
        setp(1, 1'b1, 1'b1, 12'h020, 32'h5555_aaaa, 4'hf);
        tick();
        setp(1, 1'b1, 1'b1, 12'h020, 32'h0, 4'b0011);
        tick();
        req_i[1] = 1'b0;
        rst = 1'b1;
        #1;
        chk("mrst_st", ram_st_o, 1'b0);
        tick();
        rst = 1'b0;
        setp(0, 1'b1, 1'b0, 12'h020, 32'h0, 4'h0);
        setp(1, 1'b1, 1'b0, 12'h021, 32'h0, 4'h0);
        #1;
        chk("mrst_gnt", gnt_o, 2'b01);
        tick();
        req_i[0] = 1'b0;
        #1;
        chk("mrst_rvalid", rvalid_o, 2'b01);
        chk("mrst_rdata", rdata_o, 32'h5555_aaaa);
        tick();
        tick();
        req_i[1] = 1'b0;
        tick();

        // Port 1 request withdrawn while port 0's read is in RD_RESP
        setp(0, 1'b1, 1'b0, 12'h005, 32'h0, 4'h0);
        tick();
        req_i[0] = 1'b0;
        setp(1, 1'b1, 1'b0, 12'h006, 32'h0, 4'h0);
        #1;
        chk("wd_gnt_resp", gnt_o, 2'b00);
        chk("wd_rvalid", rvalid_o, 2'b01);
        tick();
        req_i[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("wd_no_gnt1", gnt_o[1], 1'b0);
            tick();
        end

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (m_gnt[p]) begin
                    req_i[p] = 1'b0;
                    if ($urandom_range(0, 1) == 1) new_req(p);
                end else if (req_i[p] && $urandom_range(0, 15) == 0) begin
                    req_i[p] = 1'b0;
                end else if (!req_i[p] && $urandom_range(0, 2) == 0) begin
                    new_req(p);
                end
            end
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
